// File: rtl/downsampler_pkg.sv
// ----------------------------------------------------------------------------
// downsampler_pkg
// Constants and types shared by the ratio inverter and the downsampler core.
//
// Contents:
//   ONE_VALUE    - ratio 1.0 in ufix_32_31 (largest legal ratio)
//   RATIO_MIN    - smallest legal ratio; keeps 2^53/R inside 32 bits
//   INV_ONE      - 2^53 / ONE_VALUE in ufix_32_22 (reset value of the inverse)
//   DIVIDEND_HI  - 2^53 >> 32, the initial partial remainder of the divide
//   LAST_STEP    - iteration index of the final quotient bit
//   ratio_state_e   - ratio inverter FSM states
//   ratio_in_range  - range check for an incoming ratio request
// ----------------------------------------------------------------------------
package downsampler_pkg;

    localparam logic [31:0] ONE_VALUE   = 32'h8000_0000;
    localparam logic [31:0] RATIO_MIN   = 32'h0020_0001;
    localparam logic [31:0] INV_ONE     = 32'h0040_0000;

    // 2^53 = 2^21 * 2^32. The upper 21-bit part is always below the divisor
    // (R > 2^21), so only 32 quotient bits can be non-zero and the divide
    // starts with this value already in the remainder.
    localparam logic [32:0] DIVIDEND_HI = 33'h0_0020_0000;

    localparam logic [5:0]  LAST_STEP   = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } ratio_state_e;

    function automatic logic ratio_in_range(input logic [31:0] ratio);
        return (ratio >= RATIO_MIN) && (ratio <= ONE_VALUE);
    endfunction

endpackage

// File: rtl/ratio_inverter_if.sv
// ----------------------------------------------------------------------------
// ratio_inverter_if
// Stream-style request channel carrying a decimation ratio to the ratio
// inverter.
//
// Signals:
//   ratio_tdata  [31:0] requested ratio, ufix_32_31
//   ratio_tvalid        request valid (driven by master)
//   ratio_tready        receiver can accept (driven by slave)
//
// Modports:
//   master - request source
//   slave  - ratio inverter side
// ----------------------------------------------------------------------------
interface ratio_inverter_if;

    logic [31:0] ratio_tdata;
    logic        ratio_tvalid;
    logic        ratio_tready;

    modport master (
        output ratio_tdata,
        output ratio_tvalid,
        input  ratio_tready
    );

    modport slave (
        input  ratio_tdata,
        input  ratio_tvalid,
        output ratio_tready
    );

endinterface

// File: rtl/recip_divider_seq.sv
// ----------------------------------------------------------------------------
// recip_divider_seq
// Sequential restoring divider computing floor(2^53 / divisor), one quotient
// bit per clock, MSB first, 32 iterations after start.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   start     in   load divisor and begin a new divide on this edge
//   divisor   in   [31:0] divisor, must lie in RATIO_MIN..ONE_VALUE
//   done      out  high during the cycle whose closing edge resolves the
//                  last quotient bit; quotient is final after that edge
//   quotient  out  [31:0] quotient, held until the next start
// ----------------------------------------------------------------------------
module recip_divider_seq
    import downsampler_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);

    logic [31:0] divisor_q, divisor_d;
    logic [32:0] rem_q,     rem_d;
    logic [31:0] quot_q,    quot_d;
    logic [5:0]  count_q,   count_d;
    logic        busy_q,    busy_d;

    // Trial step: the low 32 bits of the dividend are all zero, so each
    // iteration shifts a zero into the remainder before the compare.
    logic [32:0] rem_shift;
    logic        take_bit;

    assign rem_shift = {rem_q[31:0], 1'b0};
    assign take_bit  = (rem_shift >= {1'b0, divisor_q});

    always_comb begin
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        count_d   = count_q;
        busy_d    = busy_q;

        if (start) begin
            divisor_d = divisor;
            rem_d     = DIVIDEND_HI;
            quot_d    = '0;
            count_d   = '0;
            busy_d    = 1'b1;
        end else if (busy_q) begin
            rem_d   = take_bit ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
            quot_d  = {quot_q[30:0], take_bit};
            count_d = count_q + 6'd1;
            if (count_q == LAST_STEP) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
        end
    end

    assign done     = busy_q && (count_q == LAST_STEP);
    assign quotient = quot_q;

endmodule

// File: rtl/ratio_inverter.sv
// ----------------------------------------------------------------------------
// ratio_inverter
// Accepts a decimation ratio R (ufix_32_31), range-checks it, computes
// floor(2^53 / R) (ufix_32_22) with a sequential divider and presents the
// pair {R, 1/R} to the downsampler core, updating both on the same edge.
//
// Ports:
//   aclk          in   clock
//   aresetn       in   asynchronous active-low reset
//   ratio_if      slave modport: ratio_tdata / ratio_tvalid / ratio_tready
//   freqRatio     out  [31:0] applied ratio
//   freqRatioInv  out  [31:0] inverse of applied ratio
//   params_valid  out  one-cycle pulse when a new pair is loaded
//   ratio_error   out  one-cycle pulse when a request is rejected
//
// Timing: accept at edge E0, new pair and params_valid at E33, ready again
// after E33, so back-to-back requests complete every 34 cycles.
// ----------------------------------------------------------------------------
module ratio_inverter
    import downsampler_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    ratio_inverter_if.slave   ratio_if,
    output logic [31:0]       freqRatio,
    output logic [31:0]       freqRatioInv,
    output logic              params_valid,
    output logic              ratio_error
);

    ratio_state_e state_q, state_d;

    logic [31:0] ratio_q,          ratio_d;
    logic [31:0] freq_ratio_q,     freq_ratio_d;
    logic [31:0] freq_ratio_inv_q, freq_ratio_inv_d;
    logic        params_valid_q,   params_valid_d;
    logic        ratio_error_q,    ratio_error_d;
    logic        ready_q,          ready_d;

    logic        accept;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quotient;

    // ready is registered so it stays low throughout reset and rises on the
    // first edge after release.
    assign accept = ratio_if.ratio_tvalid && ready_q;

    recip_divider_seq u_divider (
        .clk      (aclk),
        .rst_n    (aresetn),
        .start    (div_start),
        .divisor  (ratio_if.ratio_tdata),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_comb begin
        state_d          = state_q;
        ratio_d          = ratio_q;
        freq_ratio_d     = freq_ratio_q;
        freq_ratio_inv_d = freq_ratio_inv_q;
        params_valid_d   = 1'b0;
        ratio_error_d    = 1'b0;
        div_start        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ratio_in_range(ratio_if.ratio_tdata)) begin
                        ratio_d   = ratio_if.ratio_tdata;
                        div_start = 1'b1;
                        state_d   = CALC;
                    end else begin
                        ratio_error_d = 1'b1;
                    end
                end
            end
            CALC: begin
                // div_done marks the cycle whose edge writes the last bit.
                if (div_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                freq_ratio_d     = ratio_q;
                freq_ratio_inv_d = div_quotient;
                params_valid_d   = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q          <= IDLE;
            ratio_q          <= ONE_VALUE;
            freq_ratio_q     <= ONE_VALUE;
            freq_ratio_inv_q <= INV_ONE;
            params_valid_q   <= 1'b0;
            ratio_error_q    <= 1'b0;
            ready_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            ratio_q          <= ratio_d;
            freq_ratio_q     <= freq_ratio_d;
            freq_ratio_inv_q <= freq_ratio_inv_d;
            params_valid_q   <= params_valid_d;
            ratio_error_q    <= ratio_error_d;
            ready_q          <= ready_d;
        end
    end

    assign ratio_if.ratio_tready = ready_q;
    assign freqRatio             = freq_ratio_q;
    assign freqRatioInv          = freq_ratio_inv_q;
    assign params_valid          = params_valid_q;
    assign ratio_error           = ratio_error_q;

endmodule

// File: tb/tb_ratio_inverter.sv
// ----------------------------------------------------------------------------
// tb_ratio_inverter
// Directed self-checking bench for ratio_inverter. Inputs change on the
// falling edge or 1 ns after a rising edge; outputs are sampled 1 ns after
// the rising edge. Expected quotients are hand-computed floor(2^53 / R).
// ----------------------------------------------------------------------------
module tb_ratio_inverter;
    import downsampler_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] freqRatio;
    logic [31:0] freqRatioInv;
    logic        params_valid;
    logic        ratio_error;

    ratio_inverter_if rif ();

    ratio_inverter dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .ratio_if     (rif),
        .freqRatio    (freqRatio),
        .freqRatioInv (freqRatioInv),
        .params_valid (params_valid),
        .ratio_error  (ratio_error)
    );

    always #5 aclk = ~aclk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_ratio;
    logic [31:0] exp_inv;
    int          quiet_cnt;
    int          ready_cnt;

    // Single comparison point: counts, asserts, reports.
    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic check_reset_defaults(input string tag);
        check_output({tag, " ready"},        32'(rif.ratio_tready), 32'd0);
        check_output({tag, " freqRatio"},    freqRatio,             ONE_VALUE);
        check_output({tag, " freqRatioInv"}, freqRatioInv,          INV_ONE);
        check_output({tag, " params_valid"}, 32'(params_valid),     32'd0);
        check_output({tag, " ratio_error"},  32'(ratio_error),      32'd0);
    endtask

    // Present one request; returns 1 ns after the accepting edge E0.
    task automatic apply_stimulus(input logic [31:0] r);
        @(negedge aclk);
        rif.ratio_tdata  = r;
        rif.ratio_tvalid = 1'b1;
        @(posedge aclk);
        #1;
        rif.ratio_tvalid = 1'b0;
    endtask

    task automatic run_request(input logic [31:0] r, input logic [31:0] inv,
                               input string tag);
        int early;
        apply_stimulus(r);
        check_output({tag, " ready low in CALC"}, 32'(rif.ratio_tready), 32'd0);
        early = 0;
        repeat (32) begin
            @(posedge aclk);
            #1;
            if (params_valid || freqRatio !== exp_ratio || freqRatioInv !== exp_inv)
                early++;
        end
        check_output({tag, " quiet E1-E32"}, 32'(early), 32'd0);
        @(posedge aclk);
        #1;
        exp_ratio = r;
        exp_inv   = inv;
        check_output({tag, " freqRatio E33"},    freqRatio,             exp_ratio);
        check_output({tag, " freqRatioInv E33"}, freqRatioInv,          exp_inv);
        check_output({tag, " params_valid E33"}, 32'(params_valid),     32'd1);
        check_output({tag, " ready E33"},        32'(rif.ratio_tready), 32'd1);
        @(posedge aclk);
        #1;
        check_output({tag, " params_valid E34"}, 32'(params_valid),     32'd0);
    endtask

    task automatic run_reject(input logic [31:0] r, input string tag);
        apply_stimulus(r);
        check_output({tag, " ratio_error"},  32'(ratio_error),      32'd1);
        check_output({tag, " params_valid"}, 32'(params_valid),     32'd0);
        check_output({tag, " ready"},        32'(rif.ratio_tready), 32'd1);
        check_output({tag, " freqRatio"},    freqRatio,             exp_ratio);
        check_output({tag, " freqRatioInv"}, freqRatioInv,          exp_inv);
        @(posedge aclk);
        #1;
        check_output({tag, " error one cycle"}, 32'(ratio_error), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn          = 1'b0;
        rif.ratio_tdata  = 32'd0;
        rif.ratio_tvalid = 1'b0;
        exp_ratio        = ONE_VALUE;
        exp_inv          = INV_ONE;

        // Reset state and release.
        #12;
        check_reset_defaults("in reset");
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check_output("ready before first edge", 32'(rif.ratio_tready), 32'd0);
        @(posedge aclk);
        #1;
        check_output("ready after first edge", 32'(rif.ratio_tready), 32'd1);
        check_output("idle freqRatio",    freqRatio,    ONE_VALUE);
        check_output("idle freqRatioInv", freqRatioInv, INV_ONE);

        // In-range requests.
        run_request(32'h4000_0000, 32'h0080_0000, "r=0.5");
        run_request(32'h5555_5555, 32'h0060_0000, "r=1/3*2");
        run_request(32'h0020_0001, 32'hFFFF_F800, "r=min");

        // Out-of-range requests.
        run_reject(32'h0000_0000, "rej zero");
        run_reject(32'h0020_0000, "rej below min");
        run_reject(32'h8000_0001, "rej above one");

        run_request(32'h8000_0000, 32'h0040_0000, "r=one");

        // Second request held valid while busy.
        apply_stimulus(32'h4000_0000);
        @(negedge aclk);
        rif.ratio_tdata  = 32'h5555_5555;
        rif.ratio_tvalid = 1'b1;
        quiet_cnt = 0;
        ready_cnt = 0;
        repeat (32) begin
            @(posedge aclk);
            #1;
            if (rif.ratio_tready) ready_cnt++;
            if (params_valid)     quiet_cnt++;
        end
        check_output("stall ready low E1-E32", 32'(ready_cnt), 32'd0);
        check_output("stall no early pulse",   32'(quiet_cnt), 32'd0);
        @(posedge aclk);
        #1;
        exp_ratio = 32'h4000_0000;
        exp_inv   = 32'h0080_0000;
        check_output("stall first freqRatio",    freqRatio,             exp_ratio);
        check_output("stall first freqRatioInv", freqRatioInv,          exp_inv);
        check_output("stall first params_valid", 32'(params_valid),     32'd1);
        check_output("stall ready E33",          32'(rif.ratio_tready), 32'd1);
        @(posedge aclk);
        #1;
        rif.ratio_tvalid = 1'b0;
        check_output("stall accepted E34",      32'(rif.ratio_tready), 32'd0);
        check_output("stall pv low E34",        32'(params_valid),     32'd0);
        check_output("stall first intact E34",  freqRatioInv,          exp_inv);
        quiet_cnt = 0;
        repeat (32) begin
            @(posedge aclk);
            #1;
            if (params_valid || freqRatio !== exp_ratio || freqRatioInv !== exp_inv)
                quiet_cnt++;
        end
        check_output("stall first intact E35-E66", 32'(quiet_cnt), 32'd0);
        @(posedge aclk);
        #1;
        exp_ratio = 32'h5555_5555;
        exp_inv   = 32'h0060_0000;
        check_output("stall second freqRatio E67",    freqRatio,         exp_ratio);
        check_output("stall second freqRatioInv E67", freqRatioInv,      exp_inv);
        check_output("stall second params_valid E67", 32'(params_valid), 32'd1);
        @(posedge aclk);
        #1;

        // Reset in the middle of a calculation.
        apply_stimulus(32'h4000_0000);
        repeat (9) @(posedge aclk);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #2;
        check_reset_defaults("abort");
        exp_ratio = ONE_VALUE;
        exp_inv   = INV_ONE;
        @(negedge aclk);
        aresetn = 1'b1;
        quiet_cnt = 0;
        repeat (40) begin
            @(posedge aclk);
            #1;
            if (params_valid || freqRatio !== exp_ratio || freqRatioInv !== exp_inv)
                quiet_cnt++;
        end
        check_output("abort no result", 32'(quiet_cnt), 32'd0);
        check_output("abort ready",     32'(rif.ratio_tready), 32'd1);
        run_request(32'h0020_0001, 32'hFFFF_F800, "after abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
